// File: rtl/dds_ctrl_pkg.sv
// Shared types and helpers for the DDS carrier hop sequencer.
// Holds the state encoding, the phase width and the glide step helper.
package dds_ctrl_pkg;

  localparam int PHASE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RAMP  = 2'd2,
    DWELL = 2'd3
  } state_e;

  // 33-bit signed difference so a downward glide yields a negative step.
  function automatic logic [PHASE_W-1:0] calc_step(
    input logic [PHASE_W-1:0] tgt,
    input logic [PHASE_W-1:0] cur,
    input int unsigned        sh
  );
    logic signed [PHASE_W:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    return PHASE_W'(diff >>> sh);
  endfunction

endpackage

// File: rtl/dds_hop_table.sv
// Carrier frequency table: one synchronous write port, one combinational
// read port, cleared by the asynchronous reset.
module dds_hop_table
  import dds_ctrl_pkg::*;
#(
  parameter int SLOT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [SLOT_W-1:0]  waddr,
  input  logic [PHASE_W-1:0] wdata,
  input  logic [SLOT_W-1:0]  raddr,
  output logic [PHASE_W-1:0] rdata
);

  localparam int NUM_SLOTS = 2 ** SLOT_W;

  logic [PHASE_W-1:0] mem [NUM_SLOTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dds_hop_ctrl.sv
// Hop sequencer for the descrambler DDS: cycles through the frequency
// table, gliding linearly between slots and dwelling on each.
module dds_hop_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int SLOT_W    = 3,
  parameter int DWELL_W   = 16,
  parameter int RAMP_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SLOT_W-1:0]  cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  input  logic [SLOT_W-1:0]  last_slot,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               start,
  input  logic               stop,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               busy,
  output logic               hop_strobe,
  output logic [SLOT_W-1:0]  cur_slot
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_RAMP  = RAMP;
  localparam logic [1:0] S_DWELL = DWELL;

  localparam int RAMP_M1 = (1 << RAMP_LOG2) - 1;
  localparam logic [RAMP_LOG2:0] RAMP_LAST = RAMP_M1[RAMP_LOG2:0];

  logic [1:0]         state;
  logic [PHASE_W-1:0] step;
  logic [PHASE_W-1:0] target;
  logic [RAMP_LOG2:0] ramp_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [SLOT_W-1:0]  next_slot;
  logic [SLOT_W-1:0]  fetch_slot;
  logic [PHASE_W-1:0] fetch_data;
  logic [DWELL_W-1:0] dwell_load;
  logic               ramp_last;

  assign next_slot  = (cur_slot >= last_slot) ? '0 : cur_slot + 1'b1;
  assign fetch_slot = (state == S_IDLE) ? '0 : next_slot;
  assign dwell_load = (dwell_cycles == '0) ? '0 : dwell_cycles - 1'b1;
  assign ramp_last  = (ramp_cnt == RAMP_LAST);
  assign busy       = (state != S_IDLE);

  dds_hop_table #(
    .SLOT_W(SLOT_W)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_we),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(fetch_slot),
    .rdata(fetch_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase_inc  <= '0;
      step       <= '0;
      target     <= '0;
      ramp_cnt   <= '0;
      dwell_cnt  <= '0;
      cur_slot   <= '0;
      hop_strobe <= 1'b0;
    end else begin
      hop_strobe <= 1'b0;
      // stop leaves phase_inc wherever the glide had reached
      if (stop && state != S_IDLE) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !stop) begin
              cur_slot <= '0;
              target   <= fetch_data;
              state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            step     <= calc_step(target, phase_inc, RAMP_LOG2);
            ramp_cnt <= '0;
            state    <= S_RAMP;
          end
          S_RAMP: begin
            if (ramp_last) begin
              phase_inc  <= target;
              dwell_cnt  <= dwell_load;
              hop_strobe <= 1'b1;
              state      <= S_DWELL;
            end else begin
              phase_inc <= phase_inc + step;
              ramp_cnt  <= ramp_cnt + 1'b1;
            end
          end
          S_DWELL: begin
            if (dwell_cnt == '0) begin
              cur_slot <= next_slot;
              target   <= fetch_data;
              state    <= S_LOAD;
            end else begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_hop_ctrl.sv
// Self-checking bench for dds_hop_ctrl: vector tables through a
// scoreboard queue plus hand-written reset and dwell-zero sequences.
module tb_dds_hop_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [2:0]  last_slot = '0;
  logic [15:0] dwell_cycles = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] phase_inc;
  logic        busy;
  logic        hop_strobe;
  logic [2:0]  cur_slot;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dds_hop_ctrl #(
    .SLOT_W(3),
    .DWELL_W(16),
    .RAMP_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .last_slot(last_slot),
    .dwell_cycles(dwell_cycles),
    .start(start),
    .stop(stop),
    .phase_inc(phase_inc),
    .busy(busy),
    .hop_strobe(hop_strobe),
    .cur_slot(cur_slot)
  );

  typedef struct {
    logic        st;
    logic        sp;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [31:0] ph;
    logic        bz;
    logic        hs;
    logic [2:0]  sl;
  } vec_t;

  vec_t vq[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic st, logic sp, logic we,
                              logic [2:0] wa, logic [31:0] wd,
                              logic [31:0] ph, logic bz, logic hs,
                              logic [2:0] sl);
    vec_t v;
    v.st = st; v.sp = sp; v.we = we; v.wa = wa; v.wd = wd;
    v.ph = ph; v.bz = bz; v.hs = hs; v.sl = sl;
    return v;
  endfunction

  function automatic vec_t e(logic [31:0] ph, logic bz, logic hs,
                             logic [2:0] sl);
    return mk(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, ph, bz, hs, sl);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vecs(input string tag);
    vec_t v;
    vec_t x;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      v = vq[i];
      start = v.st; stop = v.sp;
      cfg_we = v.we; cfg_addr = v.wa; cfg_data = v.wd;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      chk($sformatf("%s[%0d].phase_inc", tag, i), phase_inc, x.ph);
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(x.bz));
      chk($sformatf("%s[%0d].hop_strobe", tag, i),
          32'(hop_strobe), 32'(x.hs));
      chk($sformatf("%s[%0d].cur_slot", tag, i), 32'(cur_slot), 32'(x.sl));
    end
    @(negedge clk);
    start = 0; stop = 0; cfg_we = 0;
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_hs(input int max, input logic [2:0] sl,
                         output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (hop_strobe && cur_slot == sl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int t[4];
    int found;
    int bad;

    #12;
    chk("rst.phase_inc", phase_inc, 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.hop_strobe", 32'(hop_strobe), 32'h0);
    chk("rst.cur_slot", 32'(cur_slot), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // stop in the middle of the first glide
    wr(3'd0, 32'h0100_0000);
    wr(3'd1, 32'h0200_0000);
    last_slot = 3'd1;
    dwell_cycles = 16'd3;
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0, 1, 0, 0));
    vq.push_back(e(32'h0000_0000, 1, 0, 0));
    vq.push_back(e(32'h0040_0000, 1, 0, 0));
    vq.push_back(e(32'h0080_0000, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h0080_0000, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 32'h0080_0000, 0, 0, 0));
    vq.push_back(e(32'h0080_0000, 0, 0, 0));
    vq.push_back(e(32'h0080_0000, 0, 0, 0));
    run_vecs("stop");

    // up-glide, down-glide with wrap, write during glide
    do_reset();
    wr(3'd0, 32'h0100_0000);
    wr(3'd1, 32'h0200_0000);
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0, 1, 0, 0));
    vq.push_back(e(32'h0000_0000, 1, 0, 0));
    vq.push_back(e(32'h0040_0000, 1, 0, 0));
    vq.push_back(e(32'h0080_0000, 1, 0, 0));
    vq.push_back(e(32'h00C0_0000, 1, 0, 0));
    vq.push_back(e(32'h0100_0000, 1, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0100_0000, 1, 0, 0));
    vq.push_back(e(32'h0100_0000, 1, 0, 0));
    vq.push_back(e(32'h0100_0000, 1, 0, 1));
    vq.push_back(e(32'h0100_0000, 1, 0, 1));
    vq.push_back(mk(0, 0, 1, 1, 32'h0300_0000, 32'h0140_0000, 1, 0, 1));
    vq.push_back(e(32'h0180_0000, 1, 0, 1));
    vq.push_back(e(32'h01C0_0000, 1, 0, 1));
    vq.push_back(e(32'h0200_0000, 1, 1, 1));
    vq.push_back(e(32'h0200_0000, 1, 0, 1));
    vq.push_back(e(32'h0200_0000, 1, 0, 1));
    vq.push_back(e(32'h0200_0000, 1, 0, 0));
    vq.push_back(e(32'h0200_0000, 1, 0, 0));
    vq.push_back(e(32'h01C0_0000, 1, 0, 0));
    vq.push_back(e(32'h0180_0000, 1, 0, 0));
    vq.push_back(e(32'h0140_0000, 1, 0, 0));
    vq.push_back(e(32'h0100_0000, 1, 1, 0));
    vq.push_back(e(32'h0100_0000, 1, 0, 0));
    vq.push_back(e(32'h0100_0000, 1, 0, 0));
    vq.push_back(e(32'h0100_0000, 1, 0, 1));
    vq.push_back(e(32'h0100_0000, 1, 0, 1));
    vq.push_back(e(32'h0180_0000, 1, 0, 1));
    vq.push_back(e(32'h0200_0000, 1, 0, 1));
    vq.push_back(e(32'h0280_0000, 1, 0, 1));
    vq.push_back(e(32'h0300_0000, 1, 1, 1));
    vq.push_back(mk(1, 1, 0, 0, 0, 32'h0300_0000, 0, 0, 1));
    vq.push_back(e(32'h0300_0000, 0, 0, 1));
    run_vecs("hop");

    // zero dwell on a single-slot sequence
    do_reset();
    wr(3'd0, 32'h0010_0000);
    last_slot = 3'd0;
    dwell_cycles = 16'd0;
    pulse_start();
    found = 0;
    bad = 0;
    for (int c = 0; c < 40 && found < 4; c++) begin
      @(posedge clk);
      #1;
      if (hop_strobe) begin
        t[found] = c;
        found++;
      end
      if (found > 0 && phase_inc !== 32'h0010_0000) bad++;
    end
    chk("single.strobes", 32'(found), 32'd4);
    for (int j = 1; j < 4; j++) begin
      if (j < found)
        chk($sformatf("single.period%0d", j), 32'(t[j] - t[j-1]), 32'd6);
    end
    chk("single.hold_errs", 32'(bad), 32'd0);
    chk("single.slot", 32'(cur_slot), 32'd0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // asynchronous reset while dwelling on slot 1
    do_reset();
    wr(3'd0, 32'h0000_0100);
    wr(3'd1, 32'h0000_0500);
    last_slot = 3'd1;
    dwell_cycles = 16'd10;
    pulse_start();
    wait_hs(80, 3'd1, ok);
    chk("arst.reach_slot1", 32'(ok), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.phase_inc", phase_inc, 32'h0);
    chk("arst.busy", 32'(busy), 32'h0);
    chk("arst.cur_slot", 32'(cur_slot), 32'h0);
    chk("arst.hop_strobe", 32'(hop_strobe), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0, 1, 0, 0));
    for (int k = 0; k < 4; k++) vq.push_back(e(32'h0, 1, 0, 0));
    vq.push_back(e(32'h0, 1, 1, 0));
    vq.push_back(e(32'h0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0));
    run_vecs("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dds_hop_ctrl.md
Name: dds_hop_ctrl

Overview:
- Sequencer that drives the 32-bit phase increment of the sine DDS carrier used by the audio descrambler.
- Holds a small table of carrier frequencies (phase increments) and steps through them cyclically.
- Each slot is held for a programmable dwell time, and each hop glides linearly from the current increment to the next.
- Sits between the register/config interface and the DDS `phase_inc` input. It is the only writer of `phase_inc`.

Parameters:
- SLOT_W, 3: slot index width; table depth NUM_SLOTS = 2**SLOT_W.
- DWELL_W, 16: width of the dwell counter, in clk cycles.
- RAMP_LOG2, 4: a glide lasts 2**RAMP_LOG2 cycles. 0 means a 1-cycle jump.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  table write enable.
- cfg_addr  in  SLOT_W  table write address.
- cfg_data  in  32  phase increment written to the table.
- last_slot  in  SLOT_W  highest slot in the hop sequence; sampled at every slot advance.
- dwell_cycles  in  DWELL_W  hold time per slot; sampled on entry to DWELL. 0 is treated as 1.
- start  in  1  single-cycle pulse that begins sequencing at slot 0.
- stop  in  1  single-cycle pulse that halts sequencing.
- phase_inc  out  32  registered increment to the DDS.
- busy  out  1  high in any state other than IDLE.
- hop_strobe  out  1  one-cycle pulse on the first DWELL cycle of each slot.
- cur_slot  out  SLOT_W  slot currently targeted or held.

Behaviour:
- Reset:
  - state=IDLE, phase_inc=0, busy=0, hop_strobe=0, cur_slot=0.
  - All table entries=0; step, target and counters=0.
- States:
  - IDLE: phase_inc holds its value. When start=1 and stop=0: cur_slot<=0, target<=table[0], go to LOAD.
  - LOAD (1 cycle): step <= (target - phase_inc) as a 33-bit signed difference, arithmetic-shifted right by RAMP_LOG2 and truncated to 32 bits; ramp_cnt<=0; go to RAMP.
  - RAMP (2**RAMP_LOG2 cycles):
    - Every cycle except the last: phase_inc <= phase_inc + step, with mod-2^32 wrap.
    - Last cycle: phase_inc <= target exactly (snap, which removes truncation error); dwell_cnt <= max(dwell_cycles,1) - 1; go to DWELL.
  - DWELL:
    - hop_strobe=1 on the first DWELL cycle only.
    - When dwell_cnt=0: next slot = 0 if cur_slot >= last_slot, else cur_slot+1. cur_slot<=next, target<=table[next], go to LOAD.
    - Otherwise dwell_cnt decrements.
- Latency:
  - For start sampled at edge k, the first phase_inc change is at edge k+2.
  - phase_inc equals the target at edge k+1+2**RAMP_LOG2.
- stop:
  - From LOAD, RAMP or DWELL: go to IDLE at the next edge. phase_inc keeps its current value, which may be an intermediate ramp value. hop_strobe=0.
  - start while busy is ignored.
  - start and stop in the same cycle: stop wins.
- Table:
  - Writes are allowed in any state.
  - target is latched on fetch, so a write to the slot being glided to or held takes effect only at its next fetch.
  - A write and a fetch of the same address in the same cycle: the fetch returns the old value.
- Boundary cases:
  - last_slot=0 re-hops to slot 0, producing a ramp of step 0 and then a hop_strobe every cycle of dwell + ramp + LOAD period.
  - target == phase_inc gives step=0 and the full ramp timing is still taken.
  - Asynchronous rst mid-operation forces the reset values immediately, including clearing the table.

Decomposition:
- Package dds_ctrl_pkg:
  - State enum (IDLE, LOAD, RAMP, DWELL).
  - PHASE_W=32 constant.
  - A helper function for the signed shifted step.
- Sub-module dds_hop_table: NUM_SLOTS x 32 register file with one synchronous write port, one combinational read port and asynchronous reset.

Test Plan:
- Upward glide. Setup: RAMP_LOG2=2; table[0]=0x01000000, table[1]=0x02000000; last_slot=1; dwell_cycles=3. Pulse start.
  - phase_inc sequence: 0x00400000, 0x00800000, 0x00C00000, 0x01000000.
  - hop_strobe on the next cycle; phase_inc holds for 3 cycles.
  - LOAD, then 0x01400000 ... 0x02000000.
- Wrap-around and downward glide. Continue the first test.
  - After slot 1's dwell, cur_slot=0.
  - phase_inc ramps down: 0x01C00000, 0x01800000, 0x01400000, 0x01000000 (negative step).
- Stop mid-ramp. Pulse stop on the second RAMP cycle.
  - Next cycle busy=0 and phase_inc=0x00800000, held.
  - start while busy, and start+stop together: no effect.
- Dwell zero and single slot. dwell_cycles=0, last_slot=0, table[0]=0x00100000.
  - Dwell lasts 1 cycle; phase_inc stays 0x00100000 after the first ramp.
  - hop_strobe period = 1 + 1 + 4 = 6 cycles.
- Write during ramp. Write table[1]=0x03000000 while gliding to slot 1.
  - The glide still ends at 0x02000000.
  - The next fetch of slot 1 targets 0x03000000.
- Async reset mid-DWELL.
  - phase_inc, busy and cur_slot go to 0 before the next clk edge.
  - A subsequent start glides from 0 toward table[0]=0.
